clkdiv_cfg_arbiter: RTL and testbench

//  Shares one integer clock divider between two configuration requesters.

---
 rtl/clkdiv_cfg_arbiter.sv | 124 ++++++++++++
 tb/tb_clkdiv_cfg_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_cfg_arbiter.sv
// Round-robin arbiter that sequences glitch-free ratio changes on a shared integer clock divider.
// Each change waits for a divided-clock low phase, gates the enable, loads the ratio, re-enables.
module clkdiv_cfg_arbiter #(
    parameter int unsigned RATIO_W     = 4,
    parameter int unsigned DEF_RATIO   = 2,
    parameter int unsigned GATE_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic               i_ref_clk,
    input  logic               i_rst_n,
    input  logic [1:0]         i_req,
    input  logic [RATIO_W-1:0] i_ratio0,
    input  logic [RATIO_W-1:0] i_ratio1,
    output logic [1:0]         o_ack,
    input  logic               i_div_clk,
    output logic [RATIO_W-1:0] o_div_ratio,
    output logic               o_clk_en,
    output logic               o_busy,
    output logic               o_cfg_err
);

    localparam int unsigned CNT_MAX = (TIMEOUT > GATE_CYCLES) ? TIMEOUT : GATE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StWaitLow,
        StGate,
        StAck
    } state_e;

    state_e             state;
    logic               rr_last;
    logic               grant;
    logic [RATIO_W-1:0] r_new;
    logic [CNT_W-1:0]   cnt;
    logic               div_prev;

    logic               req_grant;
    logic [RATIO_W-1:0] req_ratio;
    logic               div_fall;
    logic               ratio_ok;

    // On a tie the requester not served last wins; a single request wins outright.
    always_comb begin
        req_grant = (i_req == 2'b11) ? ~rr_last : i_req[1];
        req_ratio = req_grant ? i_ratio1 : i_ratio0;
        div_fall  = div_prev & ~i_div_clk;
        ratio_ok  = (o_div_ratio >= RATIO_W'(2));
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= StInit;
            o_div_ratio <= RATIO_W'(DEF_RATIO);
            o_clk_en    <= 1'b0;
            o_ack       <= 2'b00;
            o_cfg_err   <= 1'b0;
            o_busy      <= 1'b1;
            rr_last     <= 1'b1;
            grant       <= 1'b0;
            r_new       <= RATIO_W'(DEF_RATIO);
            cnt         <= '0;
            div_prev    <= 1'b0;
        end else begin
            div_prev  <= i_div_clk;
            o_ack     <= 2'b00;
            o_cfg_err <= 1'b0;
            unique case (state)
                StInit: begin
                    state    <= StIdle;
                    o_busy   <= 1'b0;
                    o_clk_en <= ratio_ok;
                end
                StIdle: begin
                    if (|i_req) begin
                        grant   <= req_grant;
                        rr_last <= req_grant;
                        r_new   <= req_ratio;
                        o_busy  <= 1'b1;
                        cnt     <= '0;
                        // Same ratio: nothing to load, acknowledge without touching the enable.
                        if (req_ratio == o_div_ratio) begin
                            state     <= StAck;
                            o_ack     <= req_grant ? 2'b10 : 2'b01;
                            o_clk_en  <= ratio_ok;
                            o_cfg_err <= ~ratio_ok;
                        end else begin
                            state <= StWaitLow;
                        end
                    end
                end
                StWaitLow: begin
                    if (div_fall || !o_clk_en || (cnt == CNT_W'(TIMEOUT - 1))) begin
                        state       <= StGate;
                        o_clk_en    <= 1'b0;
                        o_div_ratio <= r_new;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StGate: begin
                    // o_div_ratio already holds the new ratio here.
                    if (cnt == CNT_W'(GATE_CYCLES - 1)) begin
                        state     <= StAck;
                        o_ack     <= grant ? 2'b10 : 2'b01;
                        o_clk_en  <= ratio_ok;
                        o_cfg_err <= ~ratio_ok;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StAck: begin
                    state  <= StIdle;
                    o_busy <= 1'b0;
                end
                default: state <= StInit;
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_cfg_arbiter.sv
// Directed bench for clkdiv_cfg_arbiter: vector table of single transactions plus
// hand sequences for falling-edge loads, invalid ratio, ties and reset mid-sequence.
module tb_clkdiv_cfg_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [3:0] r0 = 4'd0;
    logic [3:0] r1 = 4'd0;
    logic       div_clk = 1'b0;
    logic [1:0] ack;
    logic [3:0] ratio;
    logic       en;
    logic       busy;
    logic       err;

    always #5 clk = ~clk;

    clkdiv_cfg_arbiter #(
        .RATIO_W    (4),
        .DEF_RATIO  (2),
        .GATE_CYCLES(2),
        .TIMEOUT    (16)
    ) dut (
        .i_ref_clk  (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_ratio0   (r0),
        .i_ratio1   (r1),
        .o_ack      (ack),
        .i_div_clk  (div_clk),
        .o_div_ratio(ratio),
        .o_clk_en   (en),
        .o_busy     (busy),
        .o_cfg_err  (err)
    );

    int   n_chk = 0;
    int   n_fail = 0;
    int   mode = 0;      // 0: divided clock held low, 1: held high, 2: toggling
    int   div_cnt = 0;
    logic seen_prev = 1'b0;
    logic seen_cur = 1'b0;

    typedef struct {
        logic [1:0] req;
        logic [3:0] r0;
        logic [3:0] r1;
        int         mode;
        logic [1:0] ack;
        logic [3:0] ratio;
        logic       en;
        logic       err;
        int         lat;   // negedges from request drive to the ack sample
        int         gate;  // enable-low samples before the ack
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sample point; then drive the next divided-clock value seen at the coming posedge.
    task automatic tick();
        @(negedge clk);
        seen_prev = seen_cur;
        seen_cur  = div_clk;
        div_cnt++;
        case (mode)
            0:       div_clk = 1'b0;
            1:       div_clk = 1'b1;
            default: div_clk = ((div_cnt >> 1) & 1) != 0;
        endcase
    endtask

    task automatic wait_ack(output int lat, output int en_low, output logic [1:0] a,
                            output logic e, output logic got);
        lat = 0; en_low = 0; a = 2'b00; e = 1'b0; got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            lat++;
            if (ack != 2'b00) begin
                a = ack; e = err; got = 1'b1;
                break;
            end
            if (!en) en_low++;
        end
    endtask

    int         lat;
    int         enl;
    int         cnt_ack;
    logic [1:0] a;
    logic       e;
    logic       got;
    logic       changed;
    logic       rose_again;
    vec_t       v;

    initial begin
        //            req    r0     r1     md ack    ratio  en    err   lat gate
        vecs[0] = '{2'b01, 4'd2, 4'd0, 0, 2'b01, 4'd2, 1'b1, 1'b0, 1,  0};  // same ratio
        vecs[1] = '{2'b10, 4'd0, 4'd7, 0, 2'b10, 4'd7, 1'b1, 1'b0, 19, 2};  // stuck low
        vecs[2] = '{2'b01, 4'd3, 4'd7, 1, 2'b01, 4'd3, 1'b1, 1'b0, 19, 2};  // stuck high
        vecs[3] = '{2'b10, 4'd3, 4'd0, 1, 2'b10, 4'd0, 1'b0, 1'b1, 19, 2};  // ratio 0
        vecs[4] = '{2'b01, 4'd4, 4'd0, 1, 2'b01, 4'd4, 1'b1, 1'b0, 4,  3};  // enable already low
        vecs[5] = '{2'b10, 4'd4, 4'd4, 1, 2'b10, 4'd4, 1'b1, 1'b0, 1,  0};  // same ratio

        // Reset and release
        tick(); tick();
        check("rst_ratio", ratio, 2);
        check("rst_en", en, 0);
        check("rst_busy", busy, 1);
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        #1 check("init_busy", busy, 1);
        tick();
        check("idle_busy", busy, 0);
        check("idle_en", en, 1);
        check("idle_ratio", ratio, 2);

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            mode = v.mode; r0 = v.r0; r1 = v.r1; req = v.req;
            wait_ack(lat, enl, a, e, got);
            req = 2'b00;
            check($sformatf("v%0d_got_ack", i), got, 1);
            check($sformatf("v%0d_ack", i), a, v.ack);
            check($sformatf("v%0d_lat", i), lat, v.lat);
            check($sformatf("v%0d_gate", i), enl, v.gate);
            check($sformatf("v%0d_err", i), e, v.err);
            check($sformatf("v%0d_ratio", i), ratio, v.ratio);
            check($sformatf("v%0d_en", i), en, v.en);
            tick();
            check($sformatf("v%0d_idle", i), busy, 0);
        end

        // Load with a toggling divided clock: must happen right after a falling edge
        mode = 2; r0 = 4'd5; req = 2'b01;
        changed = 1'b0; enl = 0; got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (!changed && ratio != 4'd4) begin
                changed = 1'b1;
                check("t2_fall_before_load", {seen_prev, seen_cur}, 2'b10);
            end
            if (ack != 2'b00) begin
                got = 1'b1;
                check("t2_ack", ack, 2'b01);
                break;
            end
            if (!en) enl++;
        end
        req = 2'b00;
        check("t2_got_ack", got, 1);
        check("t2_gate", enl, 2);
        tick();
        check("t2_en", en, 1);
        check("t2_ratio", ratio, 5);

        // Invalid ratio 1: enable stays low once gated, error pulses with the ack
        r1 = 4'd1; req = 2'b10;
        rose_again = 1'b0; enl = 0; got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (enl > 0 && en) rose_again = 1'b1;
            if (ack != 2'b00) begin
                got = 1'b1;
                check("t5_ack", ack, 2'b10);
                check("t5_err", err, 1);
                break;
            end
            if (!en) enl++;
        end
        req = 2'b00;
        check("t5_got_ack", got, 1);
        check("t5_en_rose", rose_again, 0);
        check("t5_ratio", ratio, 1);
        tick();
        check("t5_err_pulse", err, 0);
        check("t5_busy", busy, 0);
        tick(); tick();
        check("t5_en_low", en, 0);

        // Ties: requester 0 first, twice in a row
        mode = 1;
        for (int k = 0; k < 2; k++) begin
            r0 = 4'(6 + 3 * k); r1 = 4'(8 + 2 * k); req = 2'b11;
            wait_ack(lat, enl, a, e, got);
            check($sformatf("t3_%0d_first", k), a, 2'b01);
            req = 2'b10;
            wait_ack(lat, enl, a, e, got);
            check($sformatf("t3_%0d_second", k), a, 2'b10);
            req = 2'b00;
            check($sformatf("t3_%0d_ratio", k), ratio, 8 + 2 * k);
            tick();
        end

        // Reset while the enable is gated: no ack for the aborted grant
        r0 = 4'd11; req = 2'b01; got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (!en) begin
                got = 1'b1;
                break;
            end
        end
        check("t7_reached_gate", got, 1);
        check("t7_gate_ratio", ratio, 11);
        rst_n = 1'b0;
        #1;
        check("t7_ratio", ratio, 2);
        check("t7_en", en, 0);
        check("t7_busy", busy, 1);
        check("t7_ack", ack, 0);
        check("t7_err", err, 0);
        cnt_ack = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack != 2'b00) cnt_ack++;
        end
        req = 2'b00;
        rst_n = 1'b1;
        tick();
        check("t7_idle_busy", busy, 0);
        check("t7_idle_en", en, 1);
        for (int i = 0; i < 25; i++) begin
            tick();
            if (ack != 2'b00) cnt_ack++;
        end
        check("t7_no_ack", cnt_ack, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
